// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor
//   Watches three redundant replicas of a counter, forms the majority-voted
//   word, tracks per-replica disagreement and uncorrectable cycles, and
//   queues a timestamped event whenever the fault signature changes to a new
//   non-zero pattern.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   q_1, q_2, q_3     [WIDTH]   replica values
//   sample_en                   evaluate the replicas this cycle
//   clear                       synchronous clear of counters and evt_ovf
//   flt_cnt_1..3      [CNT_W]   saturating per-replica disagreement counts
//   unc_cnt           [CNT_W]   saturating count of uncorrectable samples
//   evt_valid/evt_ready         event stream handshake (4-entry FIFO)
//   evt_data          [4+CNT_W] {unc, mask[2:0], timestamp}
//   evt_ovf                     sticky: an event was dropped on a full FIFO
module tmr_fault_monitor #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   q_1,
    input  logic [WIDTH-1:0]   q_2,
    input  logic [WIDTH-1:0]   q_3,
    input  logic               sample_en,
    input  logic               clear,
    output logic [CNT_W-1:0]   flt_cnt_1,
    output logic [CNT_W-1:0]   flt_cnt_2,
    output logic [CNT_W-1:0]   flt_cnt_3,
    output logic [CNT_W-1:0]   unc_cnt,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [4+CNT_W-1:0] evt_data,
    output logic               evt_ovf
);

    localparam int EVT_W = 4 + CNT_W;
    localparam int DEPTH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] voted;
    logic [2:0]       mask;
    logic             unc;
    logic [2:0]       mask_prev;
    logic             unc_prev;
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] flt_cnt [3];
    logic             evt_fire;

    logic [EVT_W-1:0] fifo_mem [DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       fifo_cnt;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Voter. A replica that matches either other replica is trusted; only
    // when all three differ do we fall back to a bitwise majority and flag
    // the sample as uncorrectable.
    always_comb begin
        voted = '0;
        unc   = 1'b0;
        if (q_1 == q_2 || q_1 == q_3) begin
            voted = q_1;
        end else if (q_2 == q_3) begin
            voted = q_2;
        end else begin
            voted = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
            unc   = 1'b1;
        end
        mask = {q_3 != voted, q_2 != voted, q_1 != voted};
    end

    // Only a change into a new non-zero signature is reported; recovery to a
    // clean vote and steady-state repeats stay silent.
    assign evt_fire  = sample_en && (mask != 3'b000) &&
                       ({unc, mask} != {unc_prev, mask_prev});

    assign fifo_full = (fifo_cnt == 3'(DEPTH));
    assign evt_valid = (fifo_cnt != 3'd0);
    assign evt_data  = fifo_mem[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = evt_fire && (!fifo_full || pop);

    assign flt_cnt_1 = flt_cnt[0];
    assign flt_cnt_2 = flt_cnt[1];
    assign flt_cnt_3 = flt_cnt[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            mask_prev <= '0;
            unc_prev  <= 1'b0;
            unc_cnt   <= '0;
            evt_ovf   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            ts <= ts + CNT_W'(1);

            if (sample_en) begin
                mask_prev <= mask;
                unc_prev  <= unc;
            end

            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    flt_cnt[i] <= '0;
                end else if (sample_en && mask[i] && flt_cnt[i] != CNT_MAX) begin
                    flt_cnt[i] <= flt_cnt[i] + CNT_W'(1);
                end
            end

            if (clear) begin
                unc_cnt <= '0;
            end else if (sample_en && unc && unc_cnt != CNT_MAX) begin
                unc_cnt <= unc_cnt + CNT_W'(1);
            end

            if (clear) begin
                evt_ovf <= 1'b0;
            end else if (evt_fire && !push) begin
                evt_ovf <= 1'b1;
            end
        end
    end

    // Storage is reset too so evt_data reads zero while the FIFO is empty
    // after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {unc, mask, ts};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
module tb_tmr_fault_monitor;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int EVT_W = 4 + CNT_W;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] q_1, q_2, q_3;
    logic             sample_en;
    logic             clear;
    logic [CNT_W-1:0] flt_cnt_1, flt_cnt_2, flt_cnt_3, unc_cnt;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic             evt_ovf;

    tmr_fault_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_1       (q_1),
        .q_2       (q_2),
        .q_3       (q_3),
        .sample_en (sample_en),
        .clear     (clear),
        .flt_cnt_1 (flt_cnt_1),
        .flt_cnt_2 (flt_cnt_2),
        .flt_cnt_3 (flt_cnt_3),
        .unc_cnt   (unc_cnt),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_ovf   (evt_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on the falling edge, it first checks the DUT
    // outputs against the predicted state, then advances the prediction using
    // the inputs that the next rising edge will see.
    logic [EVT_W-1:0] sb [$];
    logic [CNT_W-1:0] m_ts, m_unc_cnt;
    logic [CNT_W-1:0] m_flt [3];
    logic [2:0]       m_mask_prev, m_mk;
    logic             m_unc_prev, m_ovf, m_u, m_pop, m_fire;
    logic [WIDTH-1:0] m_maj;
    int               m_occ;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_ts = '0; m_unc_cnt = '0; m_mask_prev = '0; m_unc_prev = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < 3; i++) m_flt[i] = '0;
        end else begin
            check_val("evt_valid", evt_valid, sb.size() != 0);
            check_val("flt_cnt_1", flt_cnt_1, m_flt[0]);
            check_val("flt_cnt_2", flt_cnt_2, m_flt[1]);
            check_val("flt_cnt_3", flt_cnt_3, m_flt[2]);
            check_val("unc_cnt", unc_cnt, m_unc_cnt);
            check_val("evt_ovf", evt_ovf, m_ovf);
            m_occ = sb.size();
            m_pop = (m_occ != 0) && evt_ready;
            if (m_occ != 0) check_val("evt_data", evt_data, sb[0]);
            if (m_pop) void'(sb.pop_front());

            // Bitwise majority equals the agreeing pair whenever two match.
            m_maj  = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
            m_u    = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
            m_mk   = {q_3 != m_maj, q_2 != m_maj, q_1 != m_maj};
            m_fire = sample_en && (m_mk != 3'b000) && ({m_u, m_mk} != {m_unc_prev, m_mask_prev});
            if (m_fire) begin
                if (m_occ < 4 || m_pop) sb.push_back({m_u, m_mk, m_ts});
                else m_ovf = 1'b1;
            end
            if (clear) m_ovf = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (clear) m_flt[i] = '0;
                else if (sample_en && m_mk[i] && m_flt[i] != CMAX) m_flt[i] = m_flt[i] + 1'b1;
            end
            if (clear) m_unc_cnt = '0;
            else if (sample_en && m_u && m_unc_cnt != CMAX) m_unc_cnt = m_unc_cnt + 1'b1;
            if (sample_en) begin
                m_mask_prev = m_mk;
                m_unc_prev  = m_u;
            end
            m_ts = m_ts + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int a, input int b, input int c);
        q_1 = WIDTH'(a);
        q_2 = WIDTH'(b);
        q_3 = WIDTH'(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        set_q(0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Six distinct fault signatures: three single faults, three uncorrectable.
    int pat [6][3] = '{'{9, 3, 3}, '{3, 9, 3}, '{3, 3, 9}, '{1, 2, 4}, '{1, 2, 3}, '{3, 1, 2}};

    initial begin
        int n_pop;
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        set_q(0, 0, 0);
        do_reset();
        check_val("rst_evt_valid", evt_valid, 1'b0);
        check_val("rst_unc_cnt", unc_cnt, 0);

        // All replicas agree: nothing counted, no events.
        set_q(5, 5, 5); sample_en = 1'b1; evt_ready = 1'b1;
        repeat (10) tick();
        sample_en = 1'b0;
        check_val("agree_flt_sum", flt_cnt_1 + flt_cnt_2 + flt_cnt_3, 0);
        check_val("agree_evt_valid", evt_valid, 1'b0);

        // Replica 2 faulty, first sample at timestamp 4.
        do_reset();
        repeat (4) tick();
        set_q(7, 9, 7); sample_en = 1'b1; evt_ready = 1'b0;
        tick();
        check_val("evt_latency", evt_valid, 1'b1);
        tick(); tick();
        sample_en = 1'b0;
        tick();
        check_val("r2_evt_data", evt_data, 8'h24);
        check_val("r2_flt_cnt_2", flt_cnt_2, 3);
        check_val("r2_flt_cnt_1", flt_cnt_1, 0);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check_val("r2_single_evt", evt_valid, 1'b0);
        set_q(7, 7, 7); sample_en = 1'b1; tick(); sample_en = 1'b0; tick();
        check_val("recover_no_evt", evt_valid, 1'b0);

        // All three differ.
        do_reset();
        set_q(1, 2, 4); sample_en = 1'b1; tick(); sample_en = 1'b0;
        check_val("unc_cnt_one", unc_cnt, 1);
        check_val("unc_flt_3", flt_cnt_3, 1);
        check_val("unc_evt_hdr", evt_data[EVT_W-1:CNT_W], 4'hF);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // Overflow with a stalled consumer, then clear, then full push+pop.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_q(pat[k][0], pat[k][1], pat[k][2]);
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
        check_val("ovf_set", evt_ovf, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("ovf_cleared", evt_ovf, 1'b0);
        check_val("clear_keeps_fifo", evt_valid, 1'b1);
        set_q(7, 9, 7); sample_en = 1'b1; evt_ready = 1'b1;
        tick();
        sample_en = 1'b0;
        n_pop = 0;
        for (int k = 0; k < 20 && evt_valid; k++) begin
            n_pop++;
            tick();
        end
        check_val("drain_count", n_pop, 4);
        check_val("push_pop_full_no_ovf", evt_ovf, 1'b0);
        evt_ready = 1'b0;

        // Saturation, then clear racing a new event.
        do_reset();
        set_q(3, 3, 6); sample_en = 1'b1; evt_ready = 1'b1;
        repeat (20) tick();
        check_val("sat_flt_cnt_3", flt_cnt_3, 15);
        set_q(9, 3, 3); clear = 1'b1; evt_ready = 1'b0;
        tick();
        clear = 1'b0; sample_en = 1'b0;
        check_val("clear_prio_flt_1", flt_cnt_1, 0);
        check_val("clear_evt_pushed", evt_valid, 1'b1);

        // Reset mid-operation with events queued.
        do_reset();
        set_q(9, 3, 3); sample_en = 1'b1; tick();
        set_q(3, 9, 3); tick();
        sample_en = 1'b0;
        check_val("pre_rst_queued", evt_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_evt_valid", evt_valid, 1'b0);
        check_val("async_flt", {flt_cnt_1, flt_cnt_2, flt_cnt_3, unc_cnt}, 0);
        check_val("async_ovf_data", {evt_ovf, evt_data}, 0);
        tick();
        rst_n = 1'b1;
        set_q(9, 3, 3); sample_en = 1'b1; tick(); sample_en = 1'b0;
        check_val("post_rst_evt", evt_valid, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 64, replica word width.
REQ-002 SHALL have parameter CNT_W, default 16, width of fault counters and timestamp.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports q_1, q_2, q_3  in  WIDTH each  replica counter values.
REQ-007 SHALL have port sample_en  in  1  evaluate replicas this cycle.
REQ-008 SHALL have port clear  in  1  synchronous clear of counters and sticky flags.
REQ-009 SHALL have ports flt_cnt_1, flt_cnt_2, flt_cnt_3  out  CNT_W each  per-replica disagreement counts.
REQ-010 SHALL have port unc_cnt  out  CNT_W  count of uncorrectable cycles.
REQ-011 SHALL have port evt_valid  out  1  event available.
REQ-012 SHALL have port evt_ready  in  1  consumer accepts event.
REQ-013 SHALL have port evt_data  out  4+CNT_W  {unc, mask[2:0], timestamp}.
REQ-014 SHALL have port evt_ovf  out  1  sticky: event dropped on full FIFO.

Function
REQ-015 SHALL form voted word combinationally: q_1 if q_1==q_2 or q_1==q_3; else q_2 if q_2==q_3; else bitwise majority with unc=1.
REQ-016 SHALL form mask[i-1] = (q_i != voted) for i=1..3; unc = 1 only when all three replicas differ pairwise.
REQ-017 SHALL, on a cycle with sample_en=1, register mask and unc into mask_prev/unc_prev; when sample_en=0, hold them and take no other action.
REQ-018 SHALL increment flt_cnt_i by 1 on every sampled cycle where mask[i-1]=1, visible next cycle; saturate at 2^CNT_W-1 (no wrap).
REQ-019 SHALL increment unc_cnt by 1 on every sampled cycle with unc=1, saturating.
REQ-020 SHALL run a free-running CNT_W timestamp counter, +1 every cycle, wrapping to 0.
REQ-021 SHALL generate an event on a sampled cycle when {unc,mask} != {unc_prev,mask_prev} and mask != 0; event carries current unc, mask, and timestamp.
REQ-022 SHALL NOT generate an event on return to mask=0 or on a repeated identical mask.
REQ-023 SHALL buffer events in a 4-entry FIFO; evt_valid = FIFO non-empty; evt_data = head entry.
REQ-024 SHALL show a pushed event on evt_valid the cycle after the sampled cycle (FIFO empty case); no combinational input-to-evt_valid path.
REQ-025 SHALL pop the head when evt_valid && evt_ready at a rising edge; evt_data stable while evt_valid=1 and evt_ready=0.
REQ-026 SHALL accept simultaneous push and pop when full (occupancy unchanged, no drop).
REQ-027 SHALL drop the event and set evt_ovf when a push occurs with FIFO full and no pop that cycle.
REQ-028 SHALL, on clear=1, zero all flt_cnt_i, unc_cnt, and evt_ovf next cycle; clear has priority over same-cycle increment/set.
REQ-029 SHALL NOT flush FIFO, mask_prev, or timestamp on clear; an event generated in a clear cycle is still pushed.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force all counters, timestamp, mask_prev, unc_prev, evt_ovf to 0 and the FIFO empty (evt_valid=0).
REQ-031 SHALL discard in-flight and buffered events on reset mid-operation; first cycle after release with sample_en=1 evaluates against mask_prev=0.

Verification
REQ-032 SHALL cover: q_1=q_2=q_3=5, sample_en=1 for 10 cycles -> all counts 0, evt_valid stays 0.
REQ-033 SHALL cover: q_2=9, q_1=q_3=7 sampled 3 cycles from timestamp 4 -> one event {0,3'b010,4}, flt_cnt_2=3, others 0.
REQ-034 SHALL cover: q_1=1, q_2=2, q_3=4 sampled once -> event unc=1, mask=3'b111, unc_cnt=1, flt_cnt_1..3=1.
REQ-035 SHALL cover: evt_ready=0, six distinct fault masks sampled -> 4 events held in order, evt_ovf=1; clear -> evt_ovf=0, FIFO still 4 deep.
REQ-036 SHALL cover: CNT_W=4, replica 3 faulty 20 sampled cycles -> flt_cnt_3 stops at 15.
REQ-037 SHALL cover: rst_n asserted with 2 events queued and counts nonzero -> evt_valid=0 and all outputs 0 immediately, before next clock edge.
